dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width on all ports.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 resetn  in  1  reset is synchronous and active-low.
REQ-004 if_req  in  1  fetch read request, held high until granted.
REQ-005 if_addr  in  ADDR_W  fetch word address, stable while if_req is high.
REQ-006 if_gnt  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid / if_rdata  out  1 / 32  fetch read response and its data.
REQ-008 mem_req  in  1  MEM-stage request, held high until granted.
REQ-009 mem_wen / mem_addr / mem_wdata  in  4 / ADDR_W / 32  byte write enables (0000 = load), address, pre-aligned store data.
REQ-010 mem_gnt  out  1  MEM request accepted this cycle.
REQ-011 mem_rvalid / mem_rdata  out  1 / 32  MEM completion (load data or store acknowledge).
REQ-012 ram_en / ram_wen / ram_addr / ram_wdata  out  1 / 4 / ADDR_W / 32  single-port synchronous RAM command.
REQ-013 ram_rdata  in  32  RAM read data, valid one cycle after the read command.

Function
REQ-014 At most one RAM command is issued per cycle, and a command is issued only in a cycle where exactly one of if_gnt or mem_gnt is high.
REQ-015 The grant is combinational from the requests in the same cycle: ram_en = if_gnt | mem_gnt, and the RAM command fields are taken from the granted port.
REQ-016 The default arbitration is fixed priority, with MEM over IF; when both ports request, mem_gnt=1 and if_gnt=0.
REQ-017 The response FSM has three states: IDLE, RESP_IF and RESP_MEM.
REQ-018 FSM next state is RESP_MEM after a mem grant, RESP_IF after an if grant, and IDLE when nothing is granted; this applies from any state.
REQ-019 In RESP_IF the block drives if_rvalid=1 and if_rdata=ram_rdata; in RESP_MEM it drives mem_rvalid=1 and mem_rdata=ram_rdata.
REQ-020 A store returns mem_rvalid one cycle after the grant, like a load; mem_rdata is don't-care for a store and the bench does not check it.
REQ-021 Latency from grant to rvalid is exactly one cycle; a new grant is allowed in the same cycle as a response, so a single port sustains one access per cycle.
REQ-022 Outside its response state, each rvalid is low and each rdata is 0.
REQ-023 The block buffers no requests; a request that is not granted must be re-presented, and the block does not store its address.
REQ-024 A request that drops before it is granted is discarded, with no side effects.

Reset
REQ-025 While resetn=0, FSM=IDLE, if_gnt=mem_gnt=0, ram_en=0, ram_wen=0, both rvalid=0 and both rdata=0.
REQ-026 Reset asserted while a response is pending drops that response; no rvalid is raised after reset is released.
REQ-027 The first grant can occur in the first cycle with resetn=1.

Configuration
REQ-028 When macro DMEM_ARB_RR_EN is defined, arbitration is round-robin using a 1-bit last-winner register; its reset value is MEM, so IF wins the first conflict, and the register is updated on every grant.
REQ-029 Without DMEM_ARB_RR_EN, arbitration is fixed priority per REQ-016, and the last-winner register is not present.

Structure
REQ-030 Package dmem_arb_pkg holds the FSM state enum, the owner encoding (OWN_IF, OWN_MEM) and the ADDR_W default.
REQ-031 Sub-module dmem_arb_pick contains the grant logic, including the round-robin option; the FSM and the response mux stay in dmem_arbiter.

Verification
REQ-032 Reset pulse mid-load: mem load granted at cycle N, resetn=0 at N+1 -> mem_rvalid stays 0 at N+1 and after.
REQ-033 Simultaneous requests, fixed priority: if_req=mem_req=1, mem_addr=0x100, mem_wen=0, RAM holds 0xDEADBEEF -> mem_gnt=1 in cycle N, mem_rvalid=1 with mem_rdata=0xDEADBEEF in cycle N+1, if_gnt=1 in cycle N+1 (once mem_req drops).
REQ-034 Store then load, back-to-back: store to 0x104 with mem_wen=1100 and mem_wdata=0xABCD0000, then a load of 0x104 -> ack in cycle N+1, load data 0xABCDxxxx in cycle N+2, low half unchanged.
REQ-035 Fetch streaming: if_req held for 4 cycles at 0x0, 0x4, 0x8, 0xC -> four consecutive if_rvalid pulses, each carrying the data of the previous cycle's address.
REQ-036 With DMEM_ARB_RR_EN, both ports continuously requesting for 6 cycles -> grants alternate IF, MEM, IF, MEM, IF, MEM.
REQ-037 Idle cycle: both requests low -> ram_en=0, FSM returns to IDLE, and both rvalid=0 in the next cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizes for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WEN_W      = 4;

    // Response FSM: which port owns the RAM read data this cycle
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESP_IF  = 2'd1,
        ST_RESP_MEM = 2'd2
    } state_t;

    // Port identity, used by the round-robin last-winner register
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arb_pick.sv
// Grant selection between fetch and MEM ports.
// Optional macro DMEM_ARB_RR_EN: round-robin via a 1-bit last-winner register;
// otherwise fixed priority with MEM over IF.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic clk,
    input  logic resetn,
`endif
    input  logic i_en,
    input  logic i_if_req,
    input  logic i_mem_req,
    output logic o_if_gnt_c,
    output logic o_mem_gnt_c
);

`ifdef DMEM_ARB_RR_EN
    owner_t r_last;
    logic   w_if_turn;

    // IF takes the conflict whenever MEM won the previous grant
    always_comb begin
        w_if_turn   = (r_last == OWN_MEM);
        o_mem_gnt_c = i_en & i_mem_req & ~(i_if_req & w_if_turn);
        o_if_gnt_c  = i_en & i_if_req & (~i_mem_req | w_if_turn);
    end

    // Last-winner register, starts as MEM so IF wins the first conflict
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last <= OWN_MEM;
        end else if (o_mem_gnt_c) begin
            r_last <= OWN_MEM;
        end else if (o_if_gnt_c) begin
            r_last <= OWN_IF;
        end
    end
`else
    // Fixed priority, MEM over IF
    always_comb begin
        o_mem_gnt_c = i_en & i_mem_req;
        o_if_gnt_c  = i_en & i_if_req & ~i_mem_req;
    end
`endif

endmodule : dmem_arb_pick

// File: rtl/dmem_arbiter.sv
// Arbitrates fetch and MEM-stage accesses onto one single-port synchronous RAM.
// Grants and RAM command are combinational; read data is steered back one
// cycle later by a small response FSM. Optional macro: DMEM_ARB_RR_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic [WEN_W-1:0]    mem_wen,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_gnt,
    output logic                mem_rvalid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                ram_en,
    output logic [WEN_W-1:0]    ram_wen,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_if_gnt;
    logic   w_mem_gnt;

    // Grant logic; reset suppresses all grants
    dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
        .clk         (clk),
        .resetn      (resetn),
`endif
        .i_en        (resetn),
        .i_if_req    (if_req),
        .i_mem_req   (mem_req),
        .o_if_gnt_c  (w_if_gnt),
        .o_mem_gnt_c (w_mem_gnt)
    );

    // RAM command taken from whichever port is granted
    always_comb begin
        if_gnt    = w_if_gnt;
        mem_gnt   = w_mem_gnt;
        ram_en    = w_if_gnt | w_mem_gnt;
        ram_wen   = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_mem_gnt) begin
            ram_wen   = mem_wen;
            ram_addr  = mem_addr;
            ram_wdata = mem_wdata;
        end else if (w_if_gnt) begin
            ram_addr  = if_addr;
        end
    end

    // Response state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state follows this cycle's grant; response mux gated by reset
    always_comb begin
        w_state_nxt = ST_IDLE;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;

        if (w_mem_gnt) begin
            w_state_nxt = ST_RESP_MEM;
        end else if (w_if_gnt) begin
            w_state_nxt = ST_RESP_IF;
        end

        if (resetn) begin
            case (r_state)
                ST_RESP_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = ram_rdata;
                end
                ST_RESP_MEM: begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ram_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule : dmem_arbiter
